ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, max instructions buffered plus in flight (power of 2, >=2).
REQ-002 SHALL have parameter AW, default 32, fetch address width.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pc  input  AW  current fetch address from the PC register.
REQ-006 flush  input  1  redirect; discard all buffered and in-flight fetches.
REQ-007 pc_adv  output  1  one-cycle pulse: the PC register shall advance.
REQ-008 ibus_req_valid  output  1  fetch request valid.
REQ-009 ibus_req_ready  input  1  bus accepts request.
REQ-010 ibus_req_addr  output  AW  word-aligned fetch address.
REQ-011 ibus_rsp_valid  input  1  response valid; in order; no backpressure.
REQ-012 ibus_rsp_data  input  32  instruction word.
REQ-013 ibus_rsp_err  input  1  bus error on this response.
REQ-014 id_valid  output  1  instruction available to decode.
REQ-015 id_ready  input  1  decode consumes instruction.
REQ-016 id_inst / id_pc  output  32 / AW  instruction and its address.
REQ-017 id_fault  output  1  entry carries a fetch fault (bus error or misalign).

Function
REQ-018 Request handshake: transfer when ibus_req_valid & ibus_req_ready; ibus_req_addr = pc; valid held with stable addr until accepted.
REQ-019 ibus_req_valid SHALL be 1 only when state is RUN, flush=0, and (buffered + in-flight) < DEPTH.
REQ-020 pc_adv SHALL equal the request handshake in the same cycle (combinational); no other source.
REQ-021 Each accepted request pushes pc into a pending-address queue; each kept response pops it and writes {pc, data, err} to the instruction buffer in the same cycle.
REQ-022 Response to buffer-output latency: 1 cycle (id_valid rises the cycle after ibus_rsp_valid).
REQ-023 Decode handshake id_valid & id_ready pops one entry; simultaneous push and pop SHALL keep count unchanged.
REQ-024 id_inst SHALL be 32'h00000013 (NOP) when id_fault=1.
REQ-025 States: RUN, DRAIN. RUN->DRAIN on flush with in-flight>0 after this cycle's accounting; DRAIN->RUN when in-flight reaches 0.
REQ-026 On flush: buffer and pending-address queue emptied next cycle; drop counter loaded with in-flight count, including a request accepted the same cycle; response in the flush cycle is dropped.
REQ-027 In DRAIN: every response decrements drop counter and is discarded; no requests issued; id_valid=0.
REQ-028 flush while in DRAIN SHALL keep DRAIN with the counter unchanged except for concurrent responses/requests.
REQ-029 Response with no outstanding request SHALL be ignored (no state change).
REQ-030 Counters wrap-free: width clog2(DEPTH)+1; full at DEPTH, never exceeded.

Reset
REQ-031 rst=1 SHALL give next cycle: state RUN, buffers empty, in-flight=0, drop=0; outputs ibus_req_valid=0, pc_adv=0, id_valid=0, id_fault=0, id_inst=0, id_pc=0.
REQ-032 Reset mid-transfer SHALL abandon outstanding fetches without entering DRAIN; the bus is reset concurrently.

Configuration
REQ-033 Macro IFETCH_MISALIGN_CHK_EN defined: pc[1:0]!=0 SHALL issue no bus request, push a fault entry (id_fault=1, id_pc=pc) directly when buffer space exists, and pulse pc_adv=0; fetch stalls until flush.
REQ-034 Macro undefined: ibus_req_addr = {pc[AW-1:2],2'b00}; no misalign faults.

Structure
REQ-035 NOP encoding, RESET_PC and fault codes SHALL live in the shared cpu.vh header.
REQ-036 Buffer and pending-address queue SHALL use one sub-module ifetch_fifo (parameterised width/depth, push/pop/flush, full/empty, count).

Verification
REQ-037 pc=0x1000, ready=1, rsp 1 cycle later 0x00500093, id_ready=1 -> id_valid with id_pc=0x1000, id_inst=0x00500093, one pc_adv pulse.
REQ-038 id_ready=0, DEPTH=2 -> exactly 2 requests issued, then ibus_req_valid=0 until one pop.
REQ-039 2 in flight, flush -> DRAIN, both responses discarded, id_valid stays 0, RUN on the cycle after the 2nd response.
REQ-040 rsp_err=1 for pc=0x2004 -> id_fault=1, id_inst=0x00000013, id_pc=0x2004.
REQ-041 IFETCH_MISALIGN_CHK_EN defined, pc=0x1002 -> no bus request, fault entry with id_pc=0x1002; undefined -> ibus_req_addr=0x1000.
REQ-042 rst asserted with 1 in flight -> outputs at reset values next cycle; late response ignored.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM states, the NOP
// encoding substituted for faulting fetches, the reset PC and fault codes.
package ifetch_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NopInst = 32'h0000_0013;
    localparam logic [31:0] ResetPc = 32'h0000_0000;

    localparam logic [1:0] FaultNone     = 2'd0;
    localparam logic [1:0] FaultBus      = 2'd1;
    localparam logic [1:0] FaultMisalign = 2'd2;

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO used for both the pending-address queue and the
// instruction buffer. DEPTH must be a power of two so the pointers wrap
// naturally. Flush empties it on the next edge and wins over push/pop.
module ifetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rptr_q];

    // Pointer and occupancy update; simultaneous push and pop keep the count.
    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
            if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: reads are only meaningful when not empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: issues word fetches at pc, tracks in-flight
// requests, buffers responses for decode and drains stale responses after a
// redirect. Optional misalignment checking is enabled by defining
// IFETCH_MISALIGN_CHK_EN; without it the low address bits are simply masked.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    input  logic          flush,
    output logic          pc_adv,
    output logic          ibus_req_valid,
    input  logic          ibus_req_ready,
    output logic [AW-1:0] ibus_req_addr,
    input  logic          ibus_rsp_valid,
    input  logic [31:0]   ibus_rsp_data,
    input  logic          ibus_rsp_err,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_inst,
    output logic [AW-1:0] id_pc,
    output logic          id_fault
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    // Buffer entry layout: {pc, inst, fault}
    localparam int unsigned EW = AW + 33;

    state_e        state_q, state_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] pq_count, ib_count;
    logic          pq_full, pq_empty, ib_full, ib_empty;
    logic [AW-1:0] pq_rdata;
    logic [EW-1:0] ib_wdata, ib_rdata;
    logic [CW:0]   total;
    logic [CW:0]   inflight_nxt;
    logic          can_fetch, req_fire, rsp_pop, ib_push, ib_pop;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic          stall_q, stall_d;
    logic          misalign, fault_push;
`endif

    assign total = {1'b0, pq_count} + {1'b0, ib_count};

    // Request issue, response acceptance and buffer write selection.
    always_comb begin
        can_fetch = (state_q == StRun) & ~flush & ~rst & ~pq_full & (total < (CW+1)'(DEPTH));
`ifdef IFETCH_MISALIGN_CHK_EN
        misalign       = (pc[1:0] != 2'b00);
        can_fetch      = can_fetch & ~stall_q;
        ibus_req_valid = can_fetch & ~misalign;
        // Wait for in-flight fetches so the fault entry lands in program order.
        fault_push     = can_fetch & misalign & pq_empty;
`else
        ibus_req_valid = can_fetch;
`endif
        ibus_req_addr = {pc[AW-1:2], 2'b00};
        req_fire      = ibus_req_valid & ibus_req_ready;
        pc_adv        = req_fire;
        // A response with nothing outstanding has no queue entry and is ignored.
        rsp_pop       = ibus_rsp_valid & ~pq_empty & (state_q == StRun);
        ib_push       = rsp_pop & ~flush & ~ib_full;
        ib_wdata      = {pq_rdata, ibus_rsp_data, ibus_rsp_err};
`ifdef IFETCH_MISALIGN_CHK_EN
        if (fault_push) begin
            ib_push  = 1'b1;
            ib_wdata = {pc, NopInst, 1'b1};
        end
`endif
    end

    // Decode-side view of the buffer head; fields read as zero when empty.
    always_comb begin
        id_valid = (state_q == StRun) & ~ib_empty;
        ib_pop   = id_valid & id_ready;
        id_fault = id_valid & ib_rdata[0];
        id_pc    = id_valid ? ib_rdata[EW-1 -: AW] : '0;
        id_inst  = '0;
        if (id_valid) id_inst = ib_rdata[0] ? NopInst : ib_rdata[32:1];
    end

    // Redirect FSM: count responses still owed by the bus and discard them.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        inflight_nxt = {1'b0, pq_count} + {{CW{1'b0}}, req_fire} - {{CW{1'b0}}, rsp_pop};
        case (state_q)
            StRun: begin
                if (flush && inflight_nxt != '0) begin
                    drop_d  = inflight_nxt[CW-1:0];
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (ibus_rsp_valid && drop_q != '0) begin
                    drop_d = drop_q - 1'b1;
                    if (drop_q == CW'(1)) state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    // A misaligned fault blocks further fetching until the next redirect.
    always_comb begin
        stall_d = stall_q;
        if (fault_push) stall_d = 1'b1;
        if (flush)      stall_d = 1'b0;
    end

    // Misalignment stall register.
    always_ff @(posedge clk) begin
        if (rst) stall_q <= 1'b0;
        else     stall_q <= stall_d;
    end
`endif

    // FSM and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    ifetch_fifo #(
        .WIDTH (AW),
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .wdata (pc),
        .pop   (rsp_pop),
        .flush (flush),
        .rdata (pq_rdata),
        .full  (pq_full),
        .empty (pq_empty),
        .count (pq_count)
    );

    ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .push  (ib_push),
        .wdata (ib_wdata),
        .pop   (ib_pop),
        .flush (flush),
        .rdata (ib_rdata),
        .full  (ib_full),
        .empty (ib_empty),
        .count (ib_count)
    );

endmodule

// File: tb/tb_ifetch.sv
// Directed table-driven bench for ifetch (DEPTH=2, AW=32). Each record gives
// one cycle of inputs and the outputs expected before the next rising edge.
module tb_ifetch;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          flush;
    logic          pc_adv;
    logic          ibus_req_valid;
    logic          ibus_req_ready;
    logic [AW-1:0] ibus_req_addr;
    logic          ibus_rsp_valid;
    logic [31:0]   ibus_rsp_data;
    logic          ibus_rsp_err;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_inst;
    logic [AW-1:0] id_pc;
    logic          id_fault;

    always #5 clk = ~clk;

    ifetch #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .flush          (flush),
        .pc_adv         (pc_adv),
        .ibus_req_valid (ibus_req_valid),
        .ibus_req_ready (ibus_req_ready),
        .ibus_req_addr  (ibus_req_addr),
        .ibus_rsp_valid (ibus_rsp_valid),
        .ibus_rsp_data  (ibus_rsp_data),
        .ibus_rsp_err   (ibus_rsp_err),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_fault       (id_fault)
    );

    typedef struct {
        logic        rst, flush;
        logic [31:0] pc;
        logic        rdy, rv;
        logic [31:0] rdata;
        logic        rerr, idr;
        logic        x_rqv, x_adv;
        logic [31:0] x_addr;
        logic        x_idv;
        logic [31:0] x_inst, x_pc;
        logic        x_flt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic [31:0] p,
                       input logic rd, input logic rv, input logic [31:0] d,
                       input logic e, input logic idr,
                       input logic q, input logic a, input logic [31:0] ad,
                       input logic iv, input logic [31:0] ins, input logic [31:0] ip,
                       input logic fl);
        vec_t v;
        v.rst = r; v.flush = f; v.pc = p; v.rdy = rd; v.rv = rv; v.rdata = d;
        v.rerr = e; v.idr = idr; v.x_rqv = q; v.x_adv = a; v.x_addr = ad;
        v.x_idv = iv; v.x_inst = ins; v.x_pc = ip; v.x_flt = fl;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        rst            = v.rst;
        flush          = v.flush;
        pc             = v.pc;
        ibus_req_ready = v.rdy;
        ibus_rsp_valid = v.rv;
        ibus_rsp_data  = v.rdata;
        ibus_rsp_err   = v.rerr;
        id_ready       = v.idr;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d req_valid", i), {31'b0, ibus_req_valid}, {31'b0, v.x_rqv});
        chk($sformatf("v%0d pc_adv", i),    {31'b0, pc_adv},         {31'b0, v.x_adv});
        chk($sformatf("v%0d req_addr", i),  ibus_req_addr,           v.x_addr);
        chk($sformatf("v%0d id_valid", i),  {31'b0, id_valid},       {31'b0, v.x_idv});
        chk($sformatf("v%0d id_inst", i),   id_inst,                 v.x_inst);
        chk($sformatf("v%0d id_pc", i),     id_pc,                   v.x_pc);
        chk($sformatf("v%0d id_fault", i),  {31'b0, id_fault},       {31'b0, v.x_flt});
    endtask

    initial begin
        int adv_cnt;
        bit found;

        rst = 1'b1; flush = 1'b0; pc = 32'h0; ibus_req_ready = 1'b0;
        ibus_rsp_valid = 1'b0; ibus_rsp_data = 32'h0; ibus_rsp_err = 1'b0; id_ready = 1'b0;
        repeat (2) @(posedge clk);

        //  rst fl pc            rdy rv data          er idr  rqv adv addr          idv inst          id_pc         flt
        // Reset state, request gated while rst is high.
        add(1, 0, 32'h0000_1000, 1, 0, 32'h0,         0, 0,   0, 0, 32'h0000_1000, 0, 32'h0,         32'h0,         0);
        // Single fetch: request, response next cycle, decode one cycle later.
        add(0, 0, 32'h0000_1000, 1, 0, 32'h0,         0, 1,   1, 1, 32'h0000_1000, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_1004, 0, 1, 32'h0050_0093, 0, 1,   1, 0, 32'h0000_1004, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_1004, 0, 0, 32'h0,         0, 1,   1, 0, 32'h0000_1004, 1, 32'h0050_0093, 32'h0000_1000, 0);
        // Decode stalled: exactly DEPTH requests, then hold off until a pop.
        add(0, 0, 32'h0000_1004, 1, 0, 32'h0,         0, 0,   1, 1, 32'h0000_1004, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_1008, 1, 0, 32'h0,         0, 0,   1, 1, 32'h0000_1008, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_100c, 1, 0, 32'h0,         0, 0,   0, 0, 32'h0000_100c, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_100c, 1, 1, 32'h1111_1111, 0, 0,   0, 0, 32'h0000_100c, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_100c, 1, 1, 32'h2222_2222, 0, 0,   0, 0, 32'h0000_100c, 1, 32'h1111_1111, 32'h0000_1004, 0);
        add(0, 0, 32'h0000_100c, 1, 0, 32'h0,         0, 0,   0, 0, 32'h0000_100c, 1, 32'h1111_1111, 32'h0000_1004, 0);
        add(0, 0, 32'h0000_100c, 1, 0, 32'h0,         0, 1,   0, 0, 32'h0000_100c, 1, 32'h1111_1111, 32'h0000_1004, 0);
        add(0, 0, 32'h0000_100c, 1, 0, 32'h0,         0, 0,   1, 1, 32'h0000_100c, 1, 32'h2222_2222, 32'h0000_1008, 0);
        add(0, 0, 32'h0000_1010, 1, 0, 32'h0,         0, 1,   0, 0, 32'h0000_1010, 1, 32'h2222_2222, 32'h0000_1008, 0);
        add(0, 0, 32'h0000_1010, 0, 1, 32'h3333_3333, 0, 1,   1, 0, 32'h0000_1010, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_1010, 0, 0, 32'h0,         0, 1,   1, 0, 32'h0000_1010, 1, 32'h3333_3333, 32'h0000_100c, 0);
        // Two in flight, flush, drain both responses, RUN after the second.
        add(0, 0, 32'h0000_2000, 1, 0, 32'h0,         0, 1,   1, 1, 32'h0000_2000, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_2004, 1, 0, 32'h0,         0, 1,   1, 1, 32'h0000_2004, 0, 32'h0,         32'h0,         0);
        add(0, 1, 32'h0000_3000, 1, 0, 32'h0,         0, 1,   0, 0, 32'h0000_3000, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_3000, 1, 1, 32'h4444_4444, 0, 1,   0, 0, 32'h0000_3000, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_3000, 1, 0, 32'h0,         0, 1,   0, 0, 32'h0000_3000, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_3000, 1, 1, 32'h5555_5555, 0, 1,   0, 0, 32'h0000_3000, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_3000, 0, 0, 32'h0,         0, 1,   1, 0, 32'h0000_3000, 0, 32'h0,         32'h0,         0);
        // Bus error turns into a NOP fault entry.
        add(0, 0, 32'h0000_2004, 1, 0, 32'h0,         0, 1,   1, 1, 32'h0000_2004, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_2008, 0, 1, 32'hffff_ffff, 1, 1,   1, 0, 32'h0000_2008, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_2008, 0, 0, 32'h0,         0, 1,   1, 0, 32'h0000_2008, 1, 32'h0000_0013, 32'h0000_2004, 1);
        // Flush while the only outstanding response arrives: no DRAIN.
        add(0, 0, 32'h0000_2008, 1, 0, 32'h0,         0, 1,   1, 1, 32'h0000_2008, 0, 32'h0,         32'h0,         0);
        add(0, 1, 32'h0000_4000, 1, 1, 32'h6666_6666, 0, 1,   0, 0, 32'h0000_4000, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_4000, 0, 0, 32'h0,         0, 1,   1, 0, 32'h0000_4000, 0, 32'h0,         32'h0,         0);
        // Misaligned pc.
`ifdef IFETCH_MISALIGN_CHK_EN
        add(0, 0, 32'h0000_1002, 0, 0, 32'h0,         0, 0,   0, 0, 32'h0000_1000, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_1002, 0, 0, 32'h0,         0, 0,   0, 0, 32'h0000_1000, 1, 32'h0000_0013, 32'h0000_1002, 1);
        add(0, 1, 32'h0000_5000, 0, 0, 32'h0,         0, 0,   0, 0, 32'h0000_5000, 1, 32'h0000_0013, 32'h0000_1002, 1);
`else
        add(0, 0, 32'h0000_1002, 0, 0, 32'h0,         0, 0,   1, 0, 32'h0000_1000, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_1002, 0, 0, 32'h0,         0, 0,   1, 0, 32'h0000_1000, 0, 32'h0,         32'h0,         0);
        add(0, 1, 32'h0000_5000, 0, 0, 32'h0,         0, 0,   0, 0, 32'h0000_5000, 0, 32'h0,         32'h0,         0);
`endif
        add(0, 0, 32'h0000_5000, 0, 0, 32'h0,         0, 0,   1, 0, 32'h0000_5000, 0, 32'h0,         32'h0,         0);
        // Reset with one in flight; the late response must be ignored.
        add(0, 0, 32'h0000_6000, 1, 0, 32'h0,         0, 1,   1, 1, 32'h0000_6000, 0, 32'h0,         32'h0,         0);
        add(1, 0, 32'h0000_6004, 1, 0, 32'h0,         0, 1,   0, 0, 32'h0000_6004, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_6004, 0, 1, 32'h7777_7777, 0, 1,   1, 0, 32'h0000_6004, 0, 32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_6004, 0, 0, 32'h0,         0, 1,   1, 0, 32'h0000_6004, 0, 32'h0,         32'h0,         0);

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check_vec(i, vecs[i]);
        end

        // Fetch at 0x8000 and wait (bounded) for it to reach decode.
        adv_cnt = 0;
        found   = 1'b0;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; pc = 32'h0000_8000; ibus_req_ready = 1'b1;
        ibus_rsp_valid = 1'b0; id_ready = 1'b1;
        #1 adv_cnt += int'(pc_adv);
        @(negedge clk);
        ibus_req_ready = 1'b0; ibus_rsp_valid = 1'b1; ibus_rsp_data = 32'h0050_0093;
        ibus_rsp_err = 1'b0;
        #1 adv_cnt += int'(pc_adv);
        @(negedge clk);
        ibus_rsp_valid = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            if (k > 0) @(negedge clk);
            #1 adv_cnt += int'(pc_adv);
            if (id_valid) begin
                found = 1'b1;
                chk("seq id_pc", id_pc, 32'h0000_8000);
                chk("seq id_inst", id_inst, 32'h0050_0093);
                chk("seq latency", k, 0);
            end
        end
        chk("seq id_valid seen", {31'b0, found}, 32'h1);
        chk("seq pc_adv pulses", adv_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
